// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised single-clock FIFO with occupancy count, programmable flags, sticky errors and flush.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through; otherwise read data is registered with 1-cycle latency.
module sync_fifo_param #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = 14,
    parameter int AE_LEVEL = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     write_en,
    input  logic [WIDTH-1:0]         data_in,
    input  logic                     read_en,
    output logic [WIDTH-1:0]         data_out,
    output logic                     rd_valid,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CW     = ADDR_W + 1;

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              full_q, full_d, empty_q, empty_d;
    logic              af_q, af_d, ae_q, ae_d;
    logic              ovf_q, ovf_d, udf_q, udf_d;
    logic              rd_ok, wr_ok;

    always_comb begin
        rd_ok    = read_en & ~empty_q;
        wr_ok    = write_en & (~full_q | rd_ok);
        wr_ptr_d = clr ? '0 : wr_ptr_q + ADDR_W'(wr_ok);
        rd_ptr_d = clr ? '0 : rd_ptr_q + ADDR_W'(rd_ok);
        count_d  = clr ? '0 : count_q + CW'(wr_ok) - CW'(rd_ok);
        ovf_d    = ~clr & (ovf_q | (write_en & full_q & ~rd_ok));
        udf_d    = ~clr & (udf_q | (read_en & empty_q));
        full_d   = count_d == CW'(DEPTH);
        empty_d  = count_d == '0;
        af_d     = count_d >= CW'(AF_LEVEL);
        ae_d     = count_d <= CW'(AE_LEVEL);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            af_q     <= 1'b0;
            ae_q     <= 1'b1;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            af_q     <= af_d;
            ae_q     <= ae_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // Storage is deliberately left unreset; a flush makes the write harmless anyway.
    always_ff @(posedge clk) begin
        if (wr_ok && !clr)
            mem_q[wr_ptr_q] <= data_in;
    end

`ifdef SYNC_FIFO_FWFT_EN
    // Gating with empty keeps data_out at zero instead of stale/unknown storage.
    assign data_out = empty_q ? '0 : mem_q[rd_ptr_q];
    assign rd_valid = ~empty_q;
`else
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             rv_q, rv_d;

    always_comb begin
        dout_d = clr ? '0 : (rd_ok ? mem_q[rd_ptr_q] : dout_q);
        rv_d   = ~clr & rd_ok;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout_q <= '0;
            rv_q   <= 1'b0;
        end else begin
            dout_q <= dout_d;
            rv_q   <= rv_d;
        end
    end

    assign data_out = dout_q;
    assign rd_valid = rv_q;
`endif

    assign count        = count_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: directed and random stimulus against a queue-based reference model.
// Covers both SYNC_FIFO_FWFT_EN settings through the same model.
module tb_sync_fifo_param;
    localparam int W = 8, D = 16, AF = 14, AE = 2;

    logic         clk = 0, rst = 0, clr = 0, write_en = 0, read_en = 0;
    logic [W-1:0] data_in = '0, data_out;
    logic         rd_valid, full, empty, almost_full, almost_empty, overflow, underflow;
    logic [4:0]   count;

    int vectors = 0, miscompares = 0;

    logic [W-1:0] q[$];
    logic         m_ov = 0, m_un = 0, m_rv = 0;
    logic [W-1:0] m_dout = '0;

    sync_fifo_param #(.WIDTH(W), .DEPTH(D), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
        .clk(clk), .rst(rst), .clr(clr), .write_en(write_en), .data_in(data_in),
        .read_en(read_en), .data_out(data_out), .rd_valid(rd_valid), .full(full),
        .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
        .count(count), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_ov = 0; m_un = 0; m_rv = 0; m_dout = '0;
    endtask

    task automatic model_step(input logic we, input logic [W-1:0] d, input logic re, input logic c);
        logic rdok, wrok;
        if (c) begin
            model_reset();
        end else begin
            rdok = re && q.size() > 0;
            wrok = we && (q.size() < D || rdok);
            if (we && q.size() == D && !rdok) m_ov = 1;
            if (re && q.size() == 0) m_un = 1;
            m_rv = rdok;
            if (rdok) m_dout = q.pop_front();
            if (wrok) q.push_back(d);
        end
    endtask

    task automatic check_all(input string tag);
        int n;
        logic [W-1:0] ed;
        logic erv;
        n = q.size();
`ifdef SYNC_FIFO_FWFT_EN
        ed  = n > 0 ? q[0] : '0;
        erv = n > 0;
`else
        ed  = m_dout;
        erv = m_rv;
`endif
        chk({tag, ".count"}, 32'(count), 32'(n));
        chk({tag, ".empty"}, 32'(empty), 32'(n == 0));
        chk({tag, ".full"}, 32'(full), 32'(n == D));
        chk({tag, ".afull"}, 32'(almost_full), 32'(n >= AF));
        chk({tag, ".aempty"}, 32'(almost_empty), 32'(n <= AE));
        chk({tag, ".ovf"}, 32'(overflow), 32'(m_ov));
        chk({tag, ".udf"}, 32'(underflow), 32'(m_un));
        chk({tag, ".rvalid"}, 32'(rd_valid), 32'(erv));
        chk({tag, ".dout"}, 32'(data_out), 32'(ed));
    endtask

    task automatic step(input string tag, input logic we, input logic [W-1:0] d, input logic re, input logic c);
        @(negedge clk);
        write_en = we; data_in = d; read_en = re; clr = c;
        @(posedge clk);
        model_step(we, d, re, c);
        #1 check_all(tag);
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1;
        #1 check_all("init");

        for (int i = 0; i < 3; i++) step("pre", 1, W'(8'hC0 + i), 0, 0);
        @(negedge clk);
        write_en = 1; data_in = 8'hEE;
        #2 rst = 0;
        #1 model_reset();
        check_all("async_rst");
        chk("async_rst.dout0", 32'(data_out), 32'h0);
        @(negedge clk);
        write_en = 0; rst = 1;
        #1 check_all("rst_release");

        for (int i = 0; i < 16; i++) step("fill", 1, W'(i), 0, 0);
        step("ovf", 1, 8'hAA, 0, 0);
        chk("ovf.count16", 32'(count), 32'd16);

        for (int i = 0; i < 16; i++) step("drain", 0, '0, 1, 0);
        step("udf", 0, '0, 1, 0);
`ifndef SYNC_FIFO_FWFT_EN
        chk("udf.hold0f", 32'(data_out), 32'h0F);
`endif

        step("clr0", 0, '0, 0, 1);
        for (int i = 0; i < 10; i++) step("w10", 1, W'(8'h10 + i), 0, 0);
        for (int i = 0; i < 10; i++) step("r10", 0, '0, 1, 0);
        for (int i = 0; i < 12; i++) step("wrapw", 1, W'(8'h20 + i), 0, 0);
        for (int i = 0; i < 12; i++) step("wrapr", 0, '0, 1, 0);

        for (int i = 0; i < 16; i++) step("fill2", 1, W'($urandom), 0, 0);
        step("both_full", 1, 8'h55, 1, 0);
        chk("both_full.count", 32'(count), 32'd16);
        for (int i = 0; i < 16; i++) step("drain2", 0, '0, 1, 0);
        step("both_empty", 1, 8'h66, 1, 0);
        chk("both_empty.count", 32'(count), 32'd1);
        step("read66", 0, '0, 1, 0);

        for (int i = 0; i < 7; i++) step("w7", 1, W'($urandom), 0, 0);
        step("clr7", 1, 8'h77, 0, 1);
        chk("clr7.count", 32'(count), 32'd0);

        for (int i = 0; i < 600; i++) begin
            int ph;
            ph = (i / 40) % 2;
            step("rand", $urandom_range(0, 99) < (ph ? 80 : 25), W'($urandom),
                 $urandom_range(0, 99) < (ph ? 25 : 80), $urandom_range(0, 149) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
